// File: rtl/sos_cascade_scheduler_pkg.sv
// sos_sched_pkg: shared types for the SOS cascade scheduler.
//   sched_state_e : scheduler FSM state encoding
//   stage_w()     : section-index width (at least 1 bit, even for one section)
package sos_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } sched_state_e;

  function automatic int unsigned stage_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sos_cascade_scheduler_if.sv
// sos_eng_if: handshake between the scheduler and the shared biquad engine.
//   eng_start         : one-cycle launch strobe (scheduler -> engine)
//   eng_stage         : section index for coefficient lookup
//   eng_x..eng_y2     : current input and section delay-line operands
//   eng_done, eng_y   : completion pulse and section result (engine -> scheduler)
// Modports: master = scheduler side, slave = engine side.
interface sos_eng_if #(
  parameter int DATA_SIZE  = 24,
  parameter int NUM_STAGES = 4
);
  import sos_sched_pkg::*;

  localparam int STG_W = stage_w(NUM_STAGES);

  logic                 eng_start;
  logic [STG_W-1:0]     eng_stage;
  logic [DATA_SIZE-1:0] eng_x;
  logic [DATA_SIZE-1:0] eng_x1;
  logic [DATA_SIZE-1:0] eng_x2;
  logic [DATA_SIZE-1:0] eng_y1;
  logic [DATA_SIZE-1:0] eng_y2;
  logic                 eng_done;
  logic [DATA_SIZE-1:0] eng_y;

  modport master (
    output eng_start, eng_stage, eng_x, eng_x1, eng_x2, eng_y1, eng_y2,
    input  eng_done, eng_y
  );

  modport slave (
    input  eng_start, eng_stage, eng_x, eng_x1, eng_x2, eng_y1, eng_y2,
    output eng_done, eng_y
  );

endinterface

// File: rtl/sos_cascade_scheduler_state_bank.sv
// sos_state_bank: per-section delay lines (x1, x2, y1, y2) for NUM_STAGES
// second-order sections. One read port (whole entry, combinational) and one
// write port (whole entry, clocked). Async active-low reset clears all words.
//   i_rd_idx -> o_x1/o_x2/o_y1/o_y2 : read port
//   i_wr_en, i_wr_idx, i_x1..i_y2    : write port
module sos_state_bank
  import sos_sched_pkg::*;
#(
  parameter int DATA_SIZE  = 24,
  parameter int NUM_STAGES = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [stage_w(NUM_STAGES)-1:0]      i_rd_idx,
  output logic [DATA_SIZE-1:0]                o_x1,
  output logic [DATA_SIZE-1:0]                o_x2,
  output logic [DATA_SIZE-1:0]                o_y1,
  output logic [DATA_SIZE-1:0]                o_y2,
  input  logic                                i_wr_en,
  input  logic [stage_w(NUM_STAGES)-1:0]      i_wr_idx,
  input  logic [DATA_SIZE-1:0]                i_x1,
  input  logic [DATA_SIZE-1:0]                i_x2,
  input  logic [DATA_SIZE-1:0]                i_y1,
  input  logic [DATA_SIZE-1:0]                i_y2
);

  logic [DATA_SIZE-1:0] r_x1 [NUM_STAGES];
  logic [DATA_SIZE-1:0] r_x2 [NUM_STAGES];
  logic [DATA_SIZE-1:0] r_y1 [NUM_STAGES];
  logic [DATA_SIZE-1:0] r_y2 [NUM_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_x1[i] <= '0;
        r_x2[i] <= '0;
        r_y1[i] <= '0;
        r_y2[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_x1[i_wr_idx] <= i_x1;
      r_x2[i_wr_idx] <= i_x2;
      r_y1[i_wr_idx] <= i_y1;
      r_y2[i_wr_idx] <= i_y2;
    end
  end

  assign o_x1 = r_x1[i_rd_idx];
  assign o_x2 = r_x2[i_rd_idx];
  assign o_y1 = r_y1[i_rd_idx];
  assign o_y2 = r_y2[i_rd_idx];

endmodule

// File: rtl/sos_cascade_scheduler.sv
// sos_cascade_scheduler: time-shares one biquad engine across NUM_STAGES
// second-order sections. Each sample walks the sections in order; the output
// of section k is the input of section k+1. No arithmetic happens here.
//   clk, reset (async, active low)
//   data_in, sample_trig     : new sample and its one-cycle strobe
//   data_out, filter_end     : cascade result and its one-cycle valid pulse
//   overrun, clear_ovr       : sticky dropped-sample flag and its clear
//   eng (sos_eng_if.master)  : engine launch / operand / result handshake
//   bypass_mask              : only with SOS_BYPASS_EN; set bit = skip section
//
// state  | meaning
// IDLE   | waiting for sample_trig
// ISSUE  | one-cycle engine launch for the current section
// WAIT   | operands held, waiting for eng_done
// UPDATE | write back section delay line, advance to next section
// DONE   | present result (filter_end), back to IDLE
module sos_cascade_scheduler
  import sos_sched_pkg::*;
#(
  parameter int COEF_SIZE  = 20,
  parameter int DATA_SIZE  = 24,
  parameter int NUM_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_SIZE-1:0]  data_in,
  input  logic                  sample_trig,
  output logic [DATA_SIZE-1:0]  data_out,
  output logic                  filter_end,
  output logic                  overrun,
  input  logic                  clear_ovr,
`ifdef SOS_BYPASS_EN
  input  logic [NUM_STAGES-1:0] bypass_mask,
`endif
  sos_eng_if.master             eng
);

  localparam int STG_W = stage_w(NUM_STAGES);

  if (NUM_STAGES < 1 || NUM_STAGES > 16 || COEF_SIZE < 1) begin : g_cfg_err
    $error("sos_cascade_scheduler: NUM_STAGES must be 1..16 and COEF_SIZE >= 1");
  end

  sched_state_e         r_state;
  sched_state_e         w_next;
  logic [STG_W-1:0]     r_stage;
  logic [DATA_SIZE-1:0] r_work;
  logic [DATA_SIZE-1:0] r_y;
  logic [DATA_SIZE-1:0] r_data_out;
  logic                 r_overrun;

  logic [STG_W-1:0]     w_stage_nxt;
  logic                 w_last;
  logic                 w_byp_cur;
  logic                 w_byp_first;
  logic                 w_byp_nxt;
  logic [DATA_SIZE-1:0] w_x1;
  logic [DATA_SIZE-1:0] w_x2;
  logic [DATA_SIZE-1:0] w_y1;
  logic [DATA_SIZE-1:0] w_y2;
  logic                 w_wr_en;

  assign w_stage_nxt = r_stage + STG_W'(1);
  assign w_last      = (r_stage == STG_W'(NUM_STAGES - 1));

`ifdef SOS_BYPASS_EN
  // w_byp_nxt is only consulted when another section follows.
  assign w_byp_cur   = bypass_mask[r_stage];
  assign w_byp_first = bypass_mask[0];
  assign w_byp_nxt   = bypass_mask[w_stage_nxt];
`else
  assign w_byp_cur   = 1'b0;
  assign w_byp_first = 1'b0;
  assign w_byp_nxt   = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (sample_trig) w_next = w_byp_first ? S_UPDATE : S_ISSUE;
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT:   if (eng.eng_done) w_next = S_UPDATE;
      S_UPDATE: begin
        if (w_last)         w_next = S_DONE;
        else if (w_byp_nxt) w_next = S_UPDATE;
        else                w_next = S_ISSUE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stage    <= '0;
      r_work     <= '0;
      r_y        <= '0;
      r_data_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (sample_trig) begin
          r_work  <= data_in;
          r_stage <= '0;
        end
        S_WAIT: if (eng.eng_done) r_y <= eng.eng_y;
        S_UPDATE: begin
          // A bypassed section passes its input straight through.
          if (!w_byp_cur) r_work <= r_y;
          if (w_last) r_data_out <= w_byp_cur ? r_work : r_y;
          else        r_stage    <= w_stage_nxt;
        end
        default: ;
      endcase
    end
  end

  // A new drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   r_overrun <= 1'b0;
    else if (sample_trig && (r_state != S_IDLE))  r_overrun <= 1'b1;
    else if (clear_ovr)                           r_overrun <= 1'b0;
  end

  assign w_wr_en = (r_state == S_UPDATE) && !w_byp_cur;

  sos_state_bank #(
    .DATA_SIZE  (DATA_SIZE),
    .NUM_STAGES (NUM_STAGES)
  ) u_bank (
    .clk      (clk),
    .rst_n    (reset),
    .i_rd_idx (r_stage),
    .o_x1     (w_x1),
    .o_x2     (w_x2),
    .o_y1     (w_y1),
    .o_y2     (w_y2),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (r_stage),
    .i_x1     (r_work),
    .i_x2     (w_x1),
    .i_y1     (r_y),
    .i_y2     (w_y1)
  );

  // Operands come from registers that only move in UPDATE, so they stay
  // stable from ISSUE through the whole WAIT.
  assign eng.eng_start = (r_state == S_ISSUE);
  assign eng.eng_stage = r_stage;
  assign eng.eng_x     = r_work;
  assign eng.eng_x1    = w_x1;
  assign eng.eng_x2    = w_x2;
  assign eng.eng_y1    = w_y1;
  assign eng.eng_y2    = w_y2;

  assign data_out   = r_data_out;
  assign filter_end = (r_state == S_DONE);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sos_cascade_scheduler.sv
// Directed bench for sos_cascade_scheduler with a behavioural engine model
// (latency LAT, mode 0: y = x, mode 1: y = x + x1).
module tb_sos_cascade_scheduler;

  localparam int DW  = 24;
  localparam int NS  = 4;
  localparam int CW  = 20;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          sample_trig = 1'b0;
  logic          clear_ovr = 1'b0;
  logic [DW-1:0] data_out;
  logic          filter_end;
  logic          overrun;
`ifdef SOS_BYPASS_EN
  logic [NS-1:0] bypass_mask = '0;
`endif

  sos_eng_if #(.DATA_SIZE(DW), .NUM_STAGES(NS)) eng();

  sos_cascade_scheduler #(
    .COEF_SIZE  (CW),
    .DATA_SIZE  (DW),
    .NUM_STAGES (NS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .sample_trig (sample_trig),
    .data_out    (data_out),
    .filter_end  (filter_end),
    .overrun     (overrun),
    .clear_ovr   (clear_ovr),
`ifdef SOS_BYPASS_EN
    .bypass_mask (bypass_mask),
`endif
    .eng         (eng)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  int            fe_cnt = 0;
  int            mode = 0;
  int            eng_cnt = 0;
  logic [DW-1:0] eng_res = '0;
  logic [15:0]   started = '0;

  // Engine model, driven on the falling edge.
  always @(negedge clk) begin
    if (filter_end) fe_cnt++;
    if (!reset) begin
      eng_cnt = 0;
      eng.eng_done = 1'b0;
    end else if (eng.eng_start) begin
      started[eng.eng_stage] = 1'b1;
      eng_res = (mode == 0) ? eng.eng_x : eng.eng_x + eng.eng_x1;
      eng_cnt = LAT;
      eng.eng_done = 1'b0;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      eng.eng_done = (eng_cnt == 0);
    end else begin
      eng.eng_done = 1'b0;
    end
    eng.eng_y = eng.eng_done ? eng_res : 24'h5A5A5A;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Leaves the caller on the negedge of the cycle after the strobe.
  task automatic trig(input logic [DW-1:0] d);
    data_in = d;
    sample_trig = 1'b1;
    @(negedge clk);
    sample_trig = 1'b0;
  endtask

  // k = cycles since the trig cycle when called right after trig().
  task automatic wait_end(output int k);
    k = 1;
    while (!filter_end && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("fe_seen", filter_end, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int k;
    int fe0;
    int g;
    eng.eng_done = 1'b0;
    eng.eng_y = '0;
    idle(2);
    chk("rst_data_out", data_out, 0);
    chk("rst_filter_end", filter_end, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_eng_start", eng.eng_start, 0);
    reset = 1'b1;
    idle(2);

    // identity engine, latency 1+4*(3+2) = 21
    mode = 0;
    started = '0;
    fe0 = fe_cnt;
    trig(24'd1000);
    wait_end(k);
    chk("lat_identity", k, 21);
    chk("dout_identity", data_out, 24'd1000);
    idle(2);
    chk("fe_count_1", fe_cnt - fe0, 1);
    chk("stages_started", started[3:0], 4'b1111);

    // negative sample passes unmodified
    trig(24'hFFFFFB);
    wait_end(k);
    chk("dout_neg", data_out, 24'hFFFFFB);
    idle(2);

    // y = x + x1 history: 100 -> 100, then 0 -> 100,200,300,400
    pulse_reset();
    mode = 1;
    trig(24'd100);
    wait_end(k);
    chk("dout_hist_a", data_out, 24'd100);
    idle(2);
    trig(24'd0);
    wait_end(k);
    chk("dout_hist_b", data_out, 24'd400);
    idle(2);

    // trig during WAIT is dropped
    mode = 0;
    fe0 = fe_cnt;
    trig(24'd1000);
    idle(3);
    trig(24'd555);
    chk("ovr_wait", overrun, 1);
    wait_end(k);
    chk("dout_after_drop", data_out, 24'd1000);
    idle(40);
    chk("fe_count_drop", fe_cnt - fe0, 1);
    chk("dout_hold", data_out, 24'd1000);
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // trig in the DONE cycle is dropped too
    fe0 = fe_cnt;
    trig(24'd321);
    wait_end(k);
    trig(24'd999);
    chk("ovr_done", overrun, 1);
    idle(40);
    chk("fe_count_done", fe_cnt - fe0, 1);
    chk("dout_done_drop", data_out, 24'd321);
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;

    // clear and a new drop in the same cycle: drop wins
    trig(24'd7);
    @(negedge clk);
    sample_trig = 1'b1;
    clear_ovr = 1'b1;
    @(negedge clk);
    sample_trig = 1'b0;
    clear_ovr = 1'b0;
    chk("ovr_clr_race", overrun, 1);
    wait_end(k);
    chk("dout_race", data_out, 24'd7);
    idle(2);

    // reset during stage 2 WAIT
    fe0 = fe_cnt;
    trig(24'd1000);
    g = 0;
    while (!(eng.eng_start && eng.eng_stage == 2) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("stage2_issue", eng.eng_start && eng.eng_stage == 2, 1);
    trig(24'd5);
    reset = 1'b0;
    #1;
    chk("mid_rst_dout", data_out, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_start", eng.eng_start, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(40);
    chk("mid_rst_no_fe", fe_cnt - fe0, 0);
    trig(24'd77);
    chk("post_rst_start", eng.eng_start, 1);
    chk("post_rst_x", eng.eng_x, 24'd77);
    chk("post_rst_x1", eng.eng_x1, 0);
    chk("post_rst_x2", eng.eng_x2, 0);
    chk("post_rst_y1", eng.eng_y1, 0);
    chk("post_rst_y2", eng.eng_y2, 0);
    wait_end(k);
    chk("dout_post_rst", data_out, 24'd77);
    idle(2);

`ifdef SOS_BYPASS_EN
    // sections 0 and 2 bypassed: 1 + 2*5 + 2*1 = 13
    pulse_reset();
    bypass_mask = 4'b0101;
    started = '0;
    trig(24'd1000);
    wait_end(k);
    chk("lat_bypass", k, 13);
    chk("stages_bypass", started[3:0], 4'b1010);
    chk("dout_bypass", data_out, 24'd1000);
    idle(2);
    bypass_mask = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
